// File: rtl/i2c_req_arbiter_if.sv
// Interface bundling the requester-side and master-side signals of i2c_req_arbiter.
//   slave  modport: arbiter view (takes req/fields/m_state, drives grant/status/m_* bus)
//   master modport: requester/master-FSM view (drives req/fields/m_state, observes the rest)
// Signals:
//   req, req_rw            per-requester request level and R/W bit
//   req_addr/mem/data      packed per-requester address (7b), memory byte, data byte
//   gnt, done, err         per-requester one-hot grant, completion pulse, timeout pulse
//   busy                   arbiter not idle
//   m_start, m_state       start request to / state code from the shared master FSM
//   m_addr/rw/mem/data     latched fields for the granted requester
interface i2c_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_mem;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   err;
  logic                 busy;
  logic                 m_start;
  logic [2:0]           m_state;
  logic [6:0]           m_addr;
  logic                 m_rw;
  logic [7:0]           m_mem;
  logic [7:0]           m_data;

  modport slave (
    input  req, req_addr, req_rw, req_mem, req_data, m_state,
    output gnt, done, err, busy, m_start, m_addr, m_rw, m_mem, m_data
  );

  modport master (
    output req, req_addr, req_rw, req_mem, req_data, m_state,
    input  gnt, done, err, busy, m_start, m_addr, m_rw, m_mem, m_data
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master FSM between NUM_REQ requesters on the scl_clk domain.
// A requester is chosen (round-robin by default), its address/R/W/memory/data fields are
// latched onto the master-side bus, m_start is raised until the master leaves IDLE, and the
// master state code is tracked through STOP back to IDLE. The granted requester then gets a
// one-cycle done pulse, or a one-cycle err pulse if the master takes too long (TIMEOUT).
// Ports:
//   scl_clk  clock shared with the master FSM
//   reset    synchronous active-high reset
//   bus      i2c_req_arbiter_if.slave (req*, gnt/done/err/busy, m_start/m_state, m_* fields)
// Build option: define I2C_ARB_FIXED_PRIO_EN for fixed priority (lowest req index wins);
// otherwise the grant rotates round-robin starting after the last served requester.
module i2c_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             scl_clk,
  input  logic             reset,
  i2c_req_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0]       MIdle   = 3'd0;
  localparam logic [2:0]       MStop   = 3'd7;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ArbIdle, ArbLaunch, ArbWait, ArbDone} arb_state_e;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               m_start_q, m_start_d;
  logic [6:0]         addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [7:0]         mem_q, mem_d;
  logic [7:0]         data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               seen_stop_q, seen_stop_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [6:0]         sel_addr;
  logic               sel_rw;
  logic [7:0]         sel_mem;
  logic [7:0]         sel_data;

`ifdef I2C_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[IDX_W'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_q, last_d;

  // Scan offsets from farthest to nearest so the nearest request after last wins.
  always_comb begin
    int j;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last_q) + k) % int'(NUM_REQ);
      if (bus.req[IDX_W'(j)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == ArbDone) begin
      last_d = idx_q;
    end
  end

  always_ff @(posedge scl_clk) begin
    if (reset) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Field mux for the requester about to be granted.
  always_comb begin
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_mem  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = bus.req_addr[7*i +: 7];
        sel_rw   = bus.req_rw[i];
        sel_mem  = bus.req_mem[8*i +: 8];
        sel_data = bus.req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    m_start_d   = m_start_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    mem_d       = mem_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    seen_stop_d = seen_stop_q;
    cnt_inc     = cnt_q + 1'b1;

    unique case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          state_d     = ArbLaunch;
          idx_d       = pick_idx;
          gnt_d       = NUM_REQ'(1) << pick_idx;
          m_start_d   = 1'b1;
          addr_d      = sel_addr;
          rw_d        = sel_rw;
          mem_d       = sel_mem;
          data_d      = sel_data;
          cnt_d       = '0;
          seen_stop_d = 1'b0;
        end
      end
      ArbLaunch: begin
        cnt_d = cnt_inc;
        if (bus.m_state != MIdle) begin
          state_d   = ArbWait;
          m_start_d = 1'b0;
        end
        if (cnt_inc == CntLast) begin
          state_d   = ArbDone;
          gnt_d     = '0;
          m_start_d = 1'b0;
          err_d     = gnt_q;
        end
      end
      ArbWait: begin
        cnt_d = cnt_inc;
        if (bus.m_state == MStop) begin
          seen_stop_d = 1'b1;
        end
        // Completion is checked first so it wins over a simultaneous timeout.
        if ((bus.m_state == MIdle) && seen_stop_q) begin
          state_d = ArbDone;
          gnt_d   = '0;
          done_d  = gnt_q;
        end else if (cnt_inc == CntLast) begin
          state_d = ArbDone;
          gnt_d   = '0;
          err_d   = gnt_q;
        end
      end
      ArbDone: begin
        state_d     = ArbIdle;
        cnt_d       = '0;
        seen_stop_d = 1'b0;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge scl_clk) begin
    if (reset) begin
      state_q     <= ArbIdle;
      idx_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      m_start_q   <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      mem_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      seen_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      m_start_q   <= m_start_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      mem_q       <= mem_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      seen_stop_q <= seen_stop_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != ArbIdle);
  assign bus.m_start = m_start_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_rw    = rw_q;
  assign bus.m_mem   = mem_q;
  assign bus.m_data  = data_q;

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares the single I2C master FSM between NUM_REQ requesters on the scl_clk domain.
- Selects one requester round-robin and latches that requester's address, R/W bit, memory byte and data byte onto the master-side bus.
- Pulses the master start input, then tracks the master state code through STOP back to IDLE.
- Reports per-requester done, or err if the master does not complete within TIMEOUT cycles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max scl_clk cycles from start pulse to master return to IDLE.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- scl_clk  in  1  clock, shared with the master FSM.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request (level).
- req_addr  in  7*NUM_REQ  packed slave addresses; requester i uses bits [7i+6:7i].
- req_rw  in  NUM_REQ  R/W bit per requester.
- req_mem  in  8*NUM_REQ  packed memory/register bytes.
- req_data  in  8*NUM_REQ  packed data bytes.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
- busy  out  1  high whenever the arbiter FSM is not in A_IDLE.
- m_start  out  1  start request to the master FSM.
- m_state  in  3  master state code: 0 IDLE, 1 START, 7 STOP.
- m_addr  out  7  latched address to the master datapath.
- m_rw  out  1  latched R/W bit.
- m_mem  out  8  latched memory byte.
- m_data  out  8  latched data byte.

Behaviour:
- Reset (synchronous, active-high):
  - FSM to A_IDLE.
  - gnt, done, err, m_start, busy, m_addr, m_rw, m_mem, m_data all 0.
  - Timeout counter 0, seen_stop 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- A_IDLE:
  - If req != 0, pick the first set bit searching last+1, last+2, … modulo NUM_REQ.
  - Register that index, set gnt one-hot, latch the four fields, go to A_LAUNCH.
  - req is sampled only in A_IDLE; request changes after grant are ignored until the next A_IDLE.
- A_LAUNCH:
  - m_start=1; counter increments each cycle.
  - When m_state != 0 (master left IDLE): m_start=0 next cycle, go to A_WAIT.
- A_WAIT:
  - Counter keeps incrementing.
  - m_state==7 sets seen_stop.
  - m_state==0 with seen_stop=1 goes to A_DONE with ok.
- Timeout:
  - In A_LAUNCH or A_WAIT, counter reaching TIMEOUT-1 goes to A_DONE with fail.
  - m_start is forced 0 that same cycle.
- A_DONE (exactly 1 cycle):
  - done[idx]=1 (ok) or err[idx]=1 (fail), never both.
  - gnt cleared, last=idx, counter and seen_stop cleared, return to A_IDLE.
  - Minimum gap between consecutive grants is 1 idle cycle.
- Latency: req high in cycle N gives gnt and m_* fields in cycle N+1 and m_start in cycle N+1.
- The m_* fields are stable from grant until A_DONE completes.
- If the timeout and completion conditions are both true in the same cycle, completion wins and done is pulsed.
- Reset asserted mid-transaction aborts immediately, with no done or err pulse. The master shares the same reset.

Optional Feature:
- Macro: I2C_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set req index always wins; last is unused.
- Undefined: round-robin as described above.
- Every other timing rule is identical in both builds.

Test Plan:
- Single request: req=4'b0010, addr=7'h50, mem=8'h10, data=8'hA5.
  - Required: gnt=4'b0010 and m_addr=7'h50 one cycle later, m_start high until m_state=1.
  - Required: done=4'b0010 pulses one cycle after the master returns 0 following 7; no err.
- Contention: req=4'b1111 held continuously across 4 transactions.
  - Required: grant order 0,1,2,3.
  - With I2C_ARB_FIXED_PRIO_EN: grant order 0,0,0,0.
- Timeout: m_state held at 0 after grant, TIMEOUT=64.
  - Required: err pulses 63 cycles after m_start rises, m_start drops, gnt clears, no done.
- Stuck mid-transfer: m_state goes 1 then sticks at 2.
  - Required: err on the cycle the counter hits 63; next request is granted normally.
- Request withdrawal: req[2] dropped 3 cycles after grant.
  - Required: transaction still completes, done[2] pulses, and the m_* fields stay constant throughout.
- Reset mid-transfer: reset asserted in A_WAIT.
  - Required: next cycle all outputs are 0 and no done/err pulse.
  - Required: with req=4'b1000 afterwards, gnt=4'b1000.
